// File: rtl/reg_write_arbiter_pkg.sv
// rtl/reg_write_arbiter_pkg.sv - register indices and state encodings for the write-port arbiter
package reg_write_arbiter_pkg;

    // Register indices shared with the core and register file
    localparam logic [3:0] REG_ZERO = 4'd0;
    localparam logic [3:0] REG_R12  = 4'd12;
    localparam logic [3:0] REG_SP   = 4'd13;

    // First and last register touched by the post-reset zero-fill
    localparam logic [3:0] INIT_FIRST = 4'd1;
    localparam logic [3:0] INIT_LAST  = 4'd15;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_ACK  = 2'd2
    } arb_state_t;

    // sp and r12 keep the values loaded by the register-file reset
    function automatic logic init_writes(input logic [3:0] idx);
        return (idx != REG_SP) && (idx != REG_R12);
    endfunction

endpackage

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - owns the register-file write port: zero-fill, core priority, host handshake
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_we,
    input  logic [3:0]  core_wreg,
    input  logic [15:0] core_wdata,
    output logic        core_stall,
    input  logic        host_req,
    input  logic [3:0]  host_wreg,
    input  logic [15:0] host_wdata,
    output logic        host_ack,
    output logic        init_busy,
    output logic        reg_write,
    output logic [3:0]  write_reg,
    output logic [15:0] write_data
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t       state, state_next;
    logic [3:0]       idx, idx_next;
    logic [CNT_W-1:0] starve_cnt, starve_next;

    // State, zero-fill walker and starvation counter; reset restarts the fill
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_INIT;
            idx        <= INIT_FIRST;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            starve_cnt <= starve_next;
        end
    end

    // The ack is the registered ACK state, so it drops the instant reset asserts
    assign host_ack = (state == ST_ACK);

    // Next-state and write-port mux; the port is combinational from state and inputs
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        starve_next = starve_cnt;
        core_stall  = 1'b0;
        init_busy   = 1'b0;
        reg_write   = 1'b0;
        write_reg   = 4'd0;
        write_data  = 16'd0;

        case (state)
            ST_INIT: begin
                init_busy  = 1'b1;
                core_stall = 1'b1;
                write_reg  = idx;
                reg_write  = init_writes(idx);
                if (idx == INIT_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    idx_next = idx + 4'd1;
                end
            end

            ST_IDLE: begin
                if (host_req && (starve_cnt == LIMIT)) begin
                    // Host has lost enough times: stall the core for one cycle
                    core_stall  = 1'b1;
                    reg_write   = 1'b1;
                    write_reg   = host_wreg;
                    write_data  = host_wdata;
                    state_next  = ST_ACK;
                    starve_next = '0;
                end else if (core_we) begin
                    reg_write  = 1'b1;
                    write_reg  = core_wreg;
                    write_data = core_wdata;
                    if (!host_req) begin
                        starve_next = '0;
                    end else if (starve_cnt != LIMIT) begin
                        starve_next = starve_cnt + 1'b1;
                    end
                end else if (host_req) begin
                    reg_write   = 1'b1;
                    write_reg   = host_wreg;
                    write_data  = host_wdata;
                    state_next  = ST_ACK;
                    starve_next = '0;
                end else begin
                    starve_next = '0;
                end
            end

            ST_ACK: begin
                // Host is ineligible this cycle; the core runs unstalled
                reg_write  = core_we;
                write_reg  = core_wreg;
                write_data = core_wdata;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_INIT;
                idx_next   = INIT_FIRST;
            end
        endcase

        // While reset is held the port is quiet and the core is held off
        if (!reset) begin
            reg_write  = 1'b0;
            core_stall = 1'b1;
            init_busy  = 1'b1;
        end
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Owns the single write port of the 16x16 CPU register file.
- After reset, sequences a zero-fill of every general register that the register-file reset does not initialise.
- In normal operation, shares the write port between core writeback (priority) and a debug/host requester, using a req/ack handshake and a starvation guard.
- Sits between the core writeback stage, the debug host interface and the register file.

Parameters:
STARVE_LIMIT, 8, consecutive cycles a pending host request may lose to the core before the core is stalled for one cycle (1..15).
CNT_W, 4, width of the starvation counter.

Ports:
clk  input  1  system clock; arbiter state updates on posedge.
reset  input  1  asynchronous, active-low reset.
core_we  input  1  core writeback request.
core_wreg  input  4  core destination register.
core_wdata  input  16  core write data.
core_stall  output  1  core must hold its writeback this cycle (combinational).
host_req  input  1  host write request; level, held until host_ack.
host_wreg  input  4  host destination register; stable while host_req=1.
host_wdata  input  16  host write data; stable while host_req=1.
host_ack  output  1  one-cycle pulse, cycle after the host write is issued (registered).
init_busy  output  1  zero-fill in progress.
reg_write  output  1  to register file write enable.
write_reg  output  4  to register file write address.
write_data  output  16  to register file write data.

Behaviour:
- Write-port outputs are combinational from state and inputs; the register file captures them at the following negedge.
- Reset (reset=0), asynchronous: state=INIT, idx=1, starve_cnt=0, host_ack=0.
- While reset=0: reg_write forced 0, core_stall=1, init_busy=1.
- Reset asserted mid-operation aborts any grant or ack; the host must re-request.
- States: INIT, IDLE, ACK.
- INIT:
  - init_busy=1, core_stall=1; core_we and host_req ignored.
  - Each cycle drives write_reg=idx, write_data=0.
  - reg_write=1 unless idx equals `sp or `r12 (skipped, reg_write=0, preserving reset values).
  - idx increments 1..15; at idx=15 goes to IDLE.
  - Exactly 15 cycles, 13 zero writes. `r_zero is never written.
- IDLE:
  - Forced host grant: if host_req=1 and starve_cnt==STARVE_LIMIT, core_stall=1 and the host write is issued. Go to ACK; starve_cnt=0.
  - Otherwise, if core_we=1: core write passes through. If host_req=1, starve_cnt increments (saturating at STARVE_LIMIT).
  - Otherwise, if host_req=1: host write issued, go to ACK, starve_cnt=0.
  - Otherwise: reg_write=0.
- ACK:
  - host_ack=1; the host is not eligible for a grant.
  - core_we passes through unstalled.
  - Next state is always IDLE.
  - The host must drop host_req during ACK; if still high in IDLE, it is treated as a new request.
- core_stall=1 means core_we is ignored and the core retries the same write next cycle. No core write is ever lost.
- Writes addressed to `r_zero are forwarded unchanged; the register file discards them.
- Host throughput: at most one write per 2 cycles.
- Core throughput: 1 write/cycle, except 1 stall cycle per forced host grant.
- starve_cnt clears whenever host_req=0 in IDLE.

Decomposition:
- Register indices `r_zero, `sp, `r12 and the state encodings come from macro_defines.v (add the INIT/IDLE/ACK encodings there).
- No sub-module; the INIT walker counter and the starvation counter live inline.

Test Plan:
1. Release reset with host_req=0, core_we=0 -> init_busy=1 for exactly 15 cycles. reg_write=1 with write_data=0 for idx 1..15 except `sp and `r12; afterwards `sp and `r12 hold their reset values.
2. After INIT: host_req=1, wreg=5, wdata=0xBEEF, core idle -> grant in that cycle: reg_write=1, write_reg=5, write_data=0xBEEF. host_ack=1 next cycle; r5 reads 0xBEEF.
3. core_we=1 with host_req=1 in the same cycle -> core write issued, host waits, host_ack=0.
4. core_we=1 continuously and host_req=1, STARVE_LIMIT=8 -> 8 core writes, then 1 cycle with core_stall=1 and the host write issued, then host_ack. The stalled core write is issued in the ACK cycle; total core writes equal the number requested.
5. Pull reset low during ACK -> host_ack=0 immediately, reg_write=0. On release, INIT repeats in full.
6. Host write to `r_zero with 0x1234 -> port drives it and host_ack pulses; r_zero still reads 0.
